// File: rtl/fp_mul_issue.sv
// Issue/retire sequencer for a multi-cycle FP multiplier: operand FIFO, run/hold control, result register.
// Optional build macro FP_MUL_ZERO_BYPASS_EN retires zero-exponent operand pairs without running the multiplier.
module fp_mul_issue #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic             mul_run,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  input  logic             mul_stall,
  input  logic [31:0]      mul_z,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Both ports are valid/ready: a transfer happens in any cycle where valid and ready are
  // high at the clock edge; valid, once raised, holds its payload until the transfer.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [4:0] CNT_LAST = 5'd25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              mul_run_q;

  logic [31:0]       fx_q [DEPTH];
  logic [31:0]       fy_q [DEPTH];
  logic [TAG_W-1:0]  ft_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              out_valid_q;
  logic [31:0]       out_z_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              err_q;

  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              capture, timeout, bypass;
  logic [TAG_W-1:0]  head_tag;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid & ~fifo_full;
  assign head_tag   = ft_q[rd_ptr_q];

`ifdef FP_MUL_ZERO_BYPASS_EN
  logic head_zero;
  assign head_zero = (fx_q[rd_ptr_q][30:23] == 8'd0) | (fy_q[rd_ptr_q][30:23] == 8'd0);
`endif

  // State register; mul_run is registered alongside so it is high exactly while in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      mul_run_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mul_run_q <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    timeout = 1'b0;
    bypass  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        // Launch only with the result register empty, so capture never overwrites.
        if (!fifo_empty && !out_valid_q) begin
`ifdef FP_MUL_ZERO_BYPASS_EN
          if (head_zero) begin
            bypass = 1'b1;
            pop    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = 5'd0;
          end
`else
          state_d = RUN;
          cnt_d   = 5'd0;
`endif
        end
      end
      RUN: begin
        if (!mul_stall) begin
          capture = 1'b1;
          pop     = 1'b1;
          state_d = GAP;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          pop     = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_run   = mul_run_q;
    busy      = (state_q != IDLE) | ~fifo_empty | out_valid_q;
    dbg_state = state_q;
  end

  // Operand FIFO; the head is only popped at retire so mul_x/mul_y hold through RUN.
  always_ff @(posedge clk) begin
    if (push) begin
      fx_q[wr_ptr_q] <= in_x;
      fy_q[wr_ptr_q] <= in_y;
      ft_q[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_z_q     <= 32'd0;
      out_tag_q   <= '0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      out_z_q     <= mul_z;
      out_tag_q   <= head_tag;
    end else if (bypass) begin
      out_valid_q <= 1'b1;
      out_z_q     <= 32'd0;
      out_tag_q   <= head_tag;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign in_ready  = ~fifo_full;
  assign mul_x     = fx_q[rd_ptr_q];
  assign mul_y     = fy_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_tag   = out_tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fp_mul_issue.sv
// Self-checking bench for fp_mul_issue with a stub multiplier that stalls 25 RUN cycles.
module tb_fp_mul_issue;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_x = '0, in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic             mul_run;
  logic [31:0]      mul_x, mul_y;
  logic             mul_stall;
  logic [31:0]      mul_z;
  logic             busy, err;
  logic [1:0]       dbg_state;

  fp_mul_issue #(.DEPTH(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag),
    .mul_run(mul_run), .mul_x(mul_x), .mul_y(mul_y), .mul_stall(mul_stall), .mul_z(mul_z),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stub multiplier
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 32'h0;
    if (x == 32'h3FC00000 && y == 32'h40000000) return 32'h40400000;
    return x ^ {y[15:0], y[31:16]};
  endfunction

  logic       stuck = 1'b0;
  logic [5:0] step = '0;
  always @(posedge clk) step <= mul_run ? step + 6'd1 : 6'd0;
  assign mul_stall = mul_run & (stuck | (step < 6'd25));
  assign mul_z     = mul_run ? model(mul_x, mul_y) : 32'hDEADBEEF;

  // scoreboard
  logic [35:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  int last_push_cyc = 0, last_pop_cyc = 0, n_push = 0, n_pop = 0;
  int ov_rises = 0, ov_rise_cyc = 0, first_run = 0, last_run = 0, run_total = 0;
  logic ov_prev = 1'b0, run_prev = 1'b0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One cycle: sample at negedge, then return just after the next posedge.
  task automatic tick();
    logic [35:0] e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        last_push_cyc = cyc;
        n_push++;
        if (!stuck) exp_q.push_back({in_tag, model(in_x, in_y)});
      end
      if (out_valid && out_ready) begin
        last_pop_cyc = cyc;
        n_pop++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {28'h0, out_tag, out_z}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("result_tag_z", {28'h0, out_tag, out_z}, {28'h0, e});
        end
      end
    end
    if (out_valid && !ov_prev) begin ov_rises++; ov_rise_cyc = cyc; end
    ov_prev = out_valid;
    if (mul_run && !run_prev) first_run = cyc;
    if (mul_run) begin last_run = cyc; run_total++; end
    run_prev = mul_run;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] tag,
                      output int c0);
    int p0 = n_push;
    int k = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_tag = tag;
    while (n_push == p0 && k < 300) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("push_handshake", 64'(n_push != p0), 64'd1);
    c0 = last_push_cyc;
  endtask

  task automatic wait_rise(input int bound, output int c);
    int r0 = ov_rises;
    int k = 0;
    while (ov_rises == r0 && k < bound) begin tick(); k++; end
    check("out_valid_timeout", 64'(ov_rises != r0), 64'd1);
    c = ov_rise_cyc;
  endtask

  task automatic wait_pop(input int bound, output int c);
    int p0 = n_pop;
    int k = 0;
    while (n_pop == p0 && k < bound) begin tick(); k++; end
    check("pop_timeout", 64'(n_pop != p0), 64'd1);
    c = last_pop_cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int c0, c1, c2, r, p1, p2, p3, rt0, k;
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_z", 64'(out_z), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_mul_run", 64'(mul_run), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // 1) basic multiply timing
    push(32'h3FC00000, 32'h40000000, 4'd5, c0);
    wait_rise(60, r);
    check("t1_latency", 64'(r - c0), 64'd28);
    check("t1_run_first", 64'(first_run - c0), 64'd2);
    check("t1_run_last", 64'(last_run - c0), 64'd27);
    tick();

    // 2) backpressure and ordering
    out_ready = 1'b0;
    push(32'h40800000, 32'h40400000, 4'd1, c0);
    push(32'h41000000, 32'h3F800000, 4'd2, c1);
    push(32'h42000000, 32'h40A00000, 4'd3, c2);
    check("t2_tag3_push_cycle", 64'(c2 - c0), 64'd28);
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    rt0 = run_total;
    for (int i = 0; i < 200; i++) tick();
    check("t2_no_run_while_held", 64'(run_total - rt0), 64'd0);
    check("t2_held_out_valid", 64'(out_valid), 64'd1);
    check("t2_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_pop(10, p1);
    wait_pop(60, p2);
    wait_pop(60, p3);
    check("t2_spacing_12", 64'(p2 - p1), 64'd28);
    check("t2_spacing_23", 64'(p3 - p2), 64'd28);
    tick();

    // 3) zero operand
    rt0 = run_total;
    push(32'h00000000, 32'h40000000, 4'd7, c0);
    wait_rise(60, r);
    for (int i = 0; i < 4; i++) tick();
`ifdef FP_MUL_ZERO_BYPASS_EN
    check("t3_latency", 64'(r - c0), 64'd2);
    check("t3_run_cycles", 64'(run_total - rt0), 64'd0);
`else
    check("t3_latency", 64'(r - c0), 64'd28);
    check("t3_run_cycles", 64'(run_total - rt0), 64'd26);
`endif

    // 4) reset mid-operation
    push(32'h3FC00000, 32'h40000000, 4'd9, c0);
    while (cyc < c0 + 12) tick();
    check("t4_running", 64'(mul_run), 64'd1);
    check("t4_step", 64'(step), 64'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_mul_run", 64'(mul_run), 64'd0);
    check("t4_in_ready", 64'(in_ready), 64'd1);
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    push(32'h40400000, 32'h40400000, 4'd10, c0);
    wait_rise(60, r);
    check("t4_fresh_latency", 64'(r - c0), 64'd28);
    tick();

    // 5) timeout with stall stuck high
    stuck = 1'b1;
    rt0 = run_total;
    c1 = ov_rises;
    push(32'h40000000, 32'h40000000, 4'd11, c0);
    while (cyc < c0 + 27) tick();
    check("t5_err_before", 64'(err), 64'd0);
    tick();
    check("t5_err_set", 64'(err), 64'd1);
    for (int i = 0; i < 40; i++) tick();
    check("t5_run_cycles", 64'(run_total - rt0), 64'd26);
    check("t5_no_result", 64'(ov_rises - c1), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    stuck = 1'b0;
    push(32'h40A00000, 32'h40000000, 4'd12, c0);
    wait_rise(60, r);
    check("t5_after_latency", 64'(r - c0), 64'd28);
    check("t5_err_sticky", 64'(err), 64'd1);
    tick();
    do_reset();
    check("t5_err_cleared", 64'(err), 64'd0);

    // 6) offer while full in the retire cycle
    push(32'h40E00000, 32'h40000000, 4'd13, c0);
    push(32'h41100000, 32'h40000000, 4'd14, c1);
    in_valid = 1'b1; in_x = 32'h41300000; in_y = 32'h40400000; in_tag = 4'd15;
    while (cyc < c0 + 27) tick();
    check("t6_retire_now", 64'({mul_run, mul_stall}), 64'b10);
    check("t6_in_ready_full", 64'(in_ready), 64'd0);
    tick();
    check("t6_in_ready_after", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t6_push_cycle", 64'(last_push_cyc - c0), 64'd28);
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin tick(); k++; end
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    // random operands with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      push($urandom, $urandom, 4'($urandom_range(0, 15)), c0);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 400) begin tick(); k++; end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
